// File: rtl/condicionador_botoes_pkg.sv
// condicionador_botoes_pkg
// Shared definitions for the button-conditioning stage of the memory game:
// press-FSM state codes (also shown on the 7-segment debug display), the
// default debounce length and small helpers that classify a button vector.
// No ports (package).
package condicionador_botoes_pkg;

  // 50000 cycles is 1 ms at 50 MHz, long enough to outlast contact bounce.
  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

  // The state code doubles as the debug display value, so it is 4 bits wide.
  typedef enum logic [3:0] {
    ESPERA         = 4'h0,
    REGISTRA       = 4'h1,
    AGUARDA_SOLTAR = 4'h2,
    INVALIDA       = 4'h3
  } estado_t;

  // True when exactly one button is pressed.
  // v & (v - 1) clears the lowest set bit; a zero result means at most one bit.
  function automatic logic eh_um_quente(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // True when two or more buttons are pressed.
  function automatic logic eh_multiplo(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'b0000;
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// condicionador_botoes_if
// Bundles the raw button inputs and the conditioned outputs that go to the
// memory-game top level.
//   master : the conditioner (reads raw buttons, drives conditioned outputs)
//   slave  : the board/top-level side (drives raw buttons, reads outputs)
// Signals:
//   botoes_brutos [3:0] raw asynchronous game buttons, active-high
//   jogar_bruto         raw asynchronous start button, active-high
//   botoes        [3:0] debounced button levels
//   jogada              one-cycle strobe per valid single-button press
//   jogada_valor  [3:0] one-hot value of the last registered press
//   jogar_pulso         one-cycle strobe on debounced rising edge of jogar
//   multiplo            high while the current press has several buttons
//   db_estado     [3:0] press-FSM state code for the debug display
interface condicionador_botoes_if;
  logic [3:0] botoes_brutos;
  logic       jogar_bruto;
  logic [3:0] botoes;
  logic       jogada;
  logic [3:0] jogada_valor;
  logic       jogar_pulso;
  logic       multiplo;
  logic [3:0] db_estado;

  modport master (
    input  botoes_brutos, jogar_bruto,
    output botoes, jogada, jogada_valor, jogar_pulso, multiplo, db_estado
  );

  modport slave (
    output botoes_brutos, jogar_bruto,
    input  botoes, jogada, jogada_valor, jogar_pulso, multiplo, db_estado
  );
endinterface

// File: rtl/condicionador_botoes_debouncer.sv
// debouncer
// Single-bit two-flop synchronizer followed by a counting debounce filter.
// The filtered level only follows the synchronized input after it has
// disagreed for DEBOUNCE_CICLOS consecutive cycles; one cycle of agreement
// restarts the count.
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous, active-high; clears synchronizer, counter, output
//   bruto    raw asynchronous input
//   filtrado debounced level
module debouncer
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto,
  output logic filtrado
);

  localparam int                 LARGURA = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [LARGURA-1:0] LIMITE  = LARGURA'(DEBOUNCE_CICLOS - 1);

  logic               sync1;
  logic               sync2;
  logic [LARGURA-1:0] contador;

  // Only sync2 is used by the filter; sync1 exists to absorb metastability.
  // The counter reaching LIMITE means this is the DEBOUNCE_CICLOS-th cycle
  // of disagreement, so the filtered level is updated on this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      contador <= '0;
      filtrado <= 1'b0;
    end else begin
      sync1 <= bruto;
      sync2 <= sync1;
      if (sync2 == filtrado) begin
        contador <= '0;
      end else if (contador == LIMITE) begin
        filtrado <= sync2;
        contador <= '0;
      end else begin
        contador <= contador + LARGURA'(1);
      end
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes
// Input-conditioning stage between the board push-buttons and the
// memory-game top level. Debounces the four game buttons and the start
// button, turns each valid single-button press into a one-cycle jogada
// strobe with a latched one-hot value, flags multi-button presses, and turns
// the start button into a one-cycle jogar_pulso.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-high; clears every flop
//   bus    condicionador_botoes_if.master (raw inputs in, conditioned out)
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                         clock,
  input  logic                         reset,
  condicionador_botoes_if.master       bus
);

  logic [3:0] botoes_filtrados;
  logic       jogar_filtrado;
  logic       jogar_anterior;
  logic       jogar_pulso_r;

  estado_t    estado;
  logic       jogada_r;
  logic [3:0] jogada_valor_r;
  logic       multiplo_r;

  // One debouncer per game button plus one for the start button.
  for (genvar i = 0; i < 4; i++) begin : g_debounce_botoes
    debouncer #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
    ) u_debouncer (
      .clock    (clock),
      .reset    (reset),
      .bruto    (bus.botoes_brutos[i]),
      .filtrado (botoes_filtrados[i])
    );
  end

  debouncer #(
    .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS)
  ) u_debouncer_jogar (
    .clock    (clock),
    .reset    (reset),
    .bruto    (bus.jogar_bruto),
    .filtrado (jogar_filtrado)
  );

  // Registered rising-edge detector on the debounced start button.
  always_ff @(posedge clock) begin
    if (reset) begin
      jogar_anterior <= 1'b0;
      jogar_pulso_r  <= 1'b0;
    end else begin
      jogar_anterior <= jogar_filtrado;
      jogar_pulso_r  <= jogar_filtrado & ~jogar_anterior;
    end
  end

  // Press FSM with registered Moore outputs. A press is classified only on
  // the cycle it leaves ESPERA; buttons added afterwards never change the
  // classification, and the FSM waits for an all-zero level before it can
  // accept another press, so one physical press gives at most one strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado         <= ESPERA;
      jogada_r       <= 1'b0;
      jogada_valor_r <= 4'b0000;
      multiplo_r     <= 1'b0;
    end else begin
      jogada_r <= 1'b0;
      case (estado)
        ESPERA: begin
          if (eh_um_quente(botoes_filtrados)) begin
            estado         <= REGISTRA;
            jogada_r       <= 1'b1;
            jogada_valor_r <= botoes_filtrados;
          end else if (eh_multiplo(botoes_filtrados)) begin
            estado     <= INVALIDA;
            multiplo_r <= 1'b1;
          end
        end
        REGISTRA: begin
          estado <= AGUARDA_SOLTAR;
        end
        AGUARDA_SOLTAR: begin
          if (botoes_filtrados == 4'b0000) begin
            estado <= ESPERA;
          end
        end
        INVALIDA: begin
          if (botoes_filtrados == 4'b0000) begin
            estado     <= ESPERA;
            multiplo_r <= 1'b0;
          end
        end
        default: begin
          estado     <= ESPERA;
          multiplo_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.botoes       = botoes_filtrados;
  assign bus.jogada       = jogada_r;
  assign bus.jogada_valor = jogada_valor_r;
  assign bus.jogar_pulso  = jogar_pulso_r;
  assign bus.multiplo     = multiplo_r;
  assign bus.db_estado    = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb_condicionador_botoes
// Directed self-checking bench for condicionador_botoes with a debounce
// length of 4 cycles. Raw inputs change on the falling edge, so the next
// rising edge is "edge 1"; outputs are sampled on the falling edge after
// each rising edge.
module tb_condicionador_botoes;

  localparam int N = 4;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;

  condicionador_botoes_if bus ();

  condicionador_botoes #(
    .DEBOUNCE_CICLOS (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive the raw buttons; call right after a falling edge.
  task automatic applyStimulus(input logic [3:0] brutos, input logic jogar);
    bus.botoes_brutos = brutos;
    bus.jogar_bruto   = jogar;
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic nextEdge();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Let all filtered levels return to zero and the FSM reach ESPERA.
  task automatic settle();
    applyStimulus(4'b0000, 1'b0);
    repeat (N + 4) nextEdge();
  endtask

  initial begin
    int strobes;
    assertCount = 0;
    failCount   = 0;

    // Reset with raw inputs idle.
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    @(negedge clock);
    repeat (3) nextEdge();
    checkOutput("rst_botoes",   32'(bus.botoes),       32'h0);
    checkOutput("rst_jogada",   32'(bus.jogada),       32'h0);
    checkOutput("rst_valor",    32'(bus.jogada_valor), 32'h0);
    checkOutput("rst_pulso",    32'(bus.jogar_pulso),  32'h0);
    checkOutput("rst_multiplo", 32'(bus.multiplo),     32'h0);
    checkOutput("rst_estado",   32'(bus.db_estado),    32'h0);
    reset = 1'b0;

    // Clean single press of button 2.
    $display("[TB] clean press 0100");
    applyStimulus(4'b0100, 1'b0);
    strobes = 0;
    for (int e = 1; e <= 20; e++) begin
      nextEdge();
      if (bus.jogada) strobes++;
      if (e == 5) checkOutput("p2_botoes_e5", 32'(bus.botoes), 32'h0);
      if (e == 6) checkOutput("p2_botoes_e6", 32'(bus.botoes), 32'h4);
      checkOutput("p2_jogada", 32'(bus.jogada), 32'((e == 7) ? 1 : 0));
    end
    checkOutput("p2_valor", 32'(bus.jogada_valor), 32'h4);
    checkOutput("p2_estado_held", 32'(bus.db_estado), 32'h2);
    applyStimulus(4'b0000, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      if (bus.jogada) strobes++;
      checkOutput("p2_rel_botoes", 32'(bus.botoes), (e < 6) ? 32'h4 : 32'h0);
      if (e == 6) checkOutput("p2_rel_est6", 32'(bus.db_estado), 32'h2);
      if (e == 7) checkOutput("p2_rel_est7", 32'(bus.db_estado), 32'h0);
    end
    checkOutput("p2_strobes", 32'(strobes), 32'd1);
    checkOutput("p2_valor_held", 32'(bus.jogada_valor), 32'h4);

    // Bouncing button 0: 2-cycle pulses never survive the 4-cycle filter.
    $display("[TB] bouncing button 0");
    for (int c = 0; c < 12; c++) begin
      applyStimulus(((c / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
      nextEdge();
      checkOutput("p3_bounce_jogada", 32'(bus.jogada), 32'h0);
      checkOutput("p3_bounce_botoes", 32'(bus.botoes), 32'h0);
    end
    applyStimulus(4'b0001, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      checkOutput("p3_jogada", 32'(bus.jogada), 32'((e == 7) ? 1 : 0));
    end
    checkOutput("p3_valor", 32'(bus.jogada_valor), 32'h1);
    settle();
    checkOutput("p3_estado_idle", 32'(bus.db_estado), 32'h0);

    // Two buttons together: invalid press, then a valid press of button 3.
    $display("[TB] multi-button press 0011");
    applyStimulus(4'b0011, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      checkOutput("p4_multiplo", 32'(bus.multiplo), 32'((e >= 7) ? 1 : 0));
      checkOutput("p4_jogada", 32'(bus.jogada), 32'h0);
    end
    checkOutput("p4_estado", 32'(bus.db_estado), 32'h3);
    checkOutput("p4_valor_kept", 32'(bus.jogada_valor), 32'h1);
    applyStimulus(4'b0000, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      nextEdge();
      checkOutput("p4_rel_multiplo", 32'(bus.multiplo), 32'((e < 7) ? 1 : 0));
    end
    applyStimulus(4'b1000, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      checkOutput("p4_b3_jogada", 32'(bus.jogada), 32'((e == 7) ? 1 : 0));
      checkOutput("p4_b3_multiplo", 32'(bus.multiplo), 32'h0);
    end
    checkOutput("p4_b3_valor", 32'(bus.jogada_valor), 32'h8);
    settle();

    // Second button added while the first is held is ignored.
    $display("[TB] late second button");
    applyStimulus(4'b0001, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      checkOutput("p5_jogada", 32'(bus.jogada), 32'((e == 7) ? 1 : 0));
    end
    applyStimulus(4'b0011, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      nextEdge();
      checkOutput("p5_late_jogada", 32'(bus.jogada), 32'h0);
      checkOutput("p5_late_multiplo", 32'(bus.multiplo), 32'h0);
    end
    checkOutput("p5_botoes", 32'(bus.botoes), 32'h3);
    checkOutput("p5_valor", 32'(bus.jogada_valor), 32'h1);
    checkOutput("p5_estado", 32'(bus.db_estado), 32'h2);
    settle();

    // Start button pulse.
    $display("[TB] jogar pulse");
    applyStimulus(4'b0000, 1'b1);
    for (int e = 1; e <= 15; e++) begin
      nextEdge();
      checkOutput("p6_pulso", 32'(bus.jogar_pulso), 32'((e == 7) ? 1 : 0));
      checkOutput("p6_jogada", 32'(bus.jogada), 32'h0);
    end
    settle();

    // Reset while button 1 is held; it must register as a fresh press.
    $display("[TB] reset mid-press");
    applyStimulus(4'b0010, 1'b0);
    repeat (3) nextEdge();
    reset = 1'b1;
    nextEdge();
    checkOutput("p6_rst_botoes", 32'(bus.botoes),       32'h0);
    checkOutput("p6_rst_valor",  32'(bus.jogada_valor), 32'h0);
    checkOutput("p6_rst_jogada", 32'(bus.jogada),       32'h0);
    checkOutput("p6_rst_estado", 32'(bus.db_estado),    32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      nextEdge();
      if (e == 5) checkOutput("p6_post_botoes_e5", 32'(bus.botoes), 32'h0);
      checkOutput("p6_post_jogada", 32'(bus.jogada), 32'((e == 7) ? 1 : 0));
    end
    checkOutput("p6_post_valor", 32'(bus.jogada_valor), 32'h2);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
